vc_buffer: RTL

VC_BUFFER -- requirements
Module: vc_buffer

---
 rtl/noc_pkg.sv | 21 ++
 rtl/vc_fifo.sv | 53 +++++
 rtl/vc_buffer.sv | 107 ++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// Shared NoC settings: default flit geometry and the helper that extracts a
// flit's virtual-channel id from its most significant bits.
package noc_pkg;

    localparam int FLIT_W = 32;
    localparam int NUM_VC = 2;
    localparam int VC_W   = $clog2(NUM_VC);
    localparam int DEPTH  = 4;

    // Generic across widths: the flit is zero-extended to 128 bits by the caller.
    function automatic int unsigned vc_field(input logic [127:0] flit,
                                             input int unsigned flit_w,
                                             input int unsigned vc_w);
        logic [127:0] shifted;
        logic [127:0] mask;
        shifted = flit >> (flit_w - vc_w);
        mask    = (128'd1 << vc_w) - 128'd1;
        return 32'(shifted & mask);
    endfunction

endpackage

// File: rtl/vc_fifo.sv
// Single virtual-channel FIFO with wrapping pointers and an occupancy count.
// A write to a full FIFO is accepted only when a read frees a slot in the same cycle.
module vc_fifo #(
    parameter int FLIT_W = noc_pkg::FLIT_W,
    parameter int DEPTH  = noc_pkg::DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [FLIT_W-1:0]        wr_data,
    input  logic                     rd_en,
    output logic [FLIT_W-1:0]        rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [FLIT_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              do_rd;
    logic              do_wr;

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(DEPTH));
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/vc_buffer.sv
// Virtual-channel input buffer: captures flits one cycle after input_read,
// demultiplexes them into per-VC FIFOs and drains them round-robin downstream.
module vc_buffer #(
    parameter int FLIT_W = noc_pkg::FLIT_W,
    parameter int NUM_VC = noc_pkg::NUM_VC,
    parameter int DEPTH  = noc_pkg::DEPTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        input_read,
    input  logic [FLIT_W-1:0]           input_data,
    output logic                        buffer_empty,
    output logic [NUM_VC-1:0]           vc_full,
    output logic                        out_valid,
    output logic [FLIT_W-1:0]           out_data,
    output logic [$clog2(NUM_VC)-1:0]   out_vc,
    input  logic                        out_ready,
    output logic                        overflow
);

    localparam int VC_W = $clog2(NUM_VC);
    localparam int CW   = $clog2(DEPTH) + 1;

    import noc_pkg::*;

    // Handshake: a flit moves downstream on any edge where out_valid && out_ready;
    // once offered, the flit and its VC stay fixed until that transfer happens.

    logic              wr_pending;
    logic [VC_W-1:0]   wr_vc;
    logic [VC_W-1:0]   rr_ptr;
    logic              hold_valid;
    logic [VC_W-1:0]   hold_vc;
    logic [VC_W-1:0]   search_vc;
    logic [VC_W-1:0]   idx;
    logic [VC_W-1:0]   grant;
    logic              found;
    logic              occupied;
    logic              xfer;
    logic              overflow_set;

    logic [NUM_VC-1:0] wr_en;
    logic [NUM_VC-1:0] rd_en;
    logic [NUM_VC-1:0] empty;
    logic [FLIT_W-1:0] rd_data [NUM_VC];
    logic [CW-1:0]     count   [NUM_VC];

    assign wr_vc = VC_W'(vc_field(128'(input_data), FLIT_W, VC_W));

    for (genvar g = 0; g < NUM_VC; g++) begin : g_vc
        assign wr_en[g] = wr_pending && (wr_vc == VC_W'(g));
        assign rd_en[g] = xfer && (grant == VC_W'(g));

        vc_fifo #(.FLIT_W(FLIT_W), .DEPTH(DEPTH)) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .wr_en   (wr_en[g]),
            .wr_data (input_data),
            .rd_en   (rd_en[g]),
            .rd_data (rd_data[g]),
            .empty   (empty[g]),
            .full    (vc_full[g]),
            .count   (count[g])
        );
    end

    // Round-robin search from rr_ptr; a stalled offer is pinned by hold_vc so a
    // newly filled VC closer to rr_ptr cannot steal the grant.
    always_comb begin
        found     = 1'b0;
        search_vc = rr_ptr;
        idx       = '0;
        occupied  = 1'b0;
        for (int i = 0; i < NUM_VC; i++) begin
            idx = rr_ptr + VC_W'(i);
            if (!found && !empty[idx]) begin
                found     = 1'b1;
                search_vc = idx;
            end
            occupied = occupied || (count[i] != '0);
        end
        grant        = hold_valid ? hold_vc : search_vc;
        out_valid    = hold_valid || found;
        out_vc       = out_valid ? grant : '0;
        out_data     = out_valid ? rd_data[grant] : '0;
        xfer         = out_valid && out_ready;
        overflow_set = wr_pending && vc_full[wr_vc] && !rd_en[wr_vc];
        buffer_empty = !occupied && !wr_pending;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_pending <= 1'b0;
            rr_ptr     <= '0;
            hold_valid <= 1'b0;
            hold_vc    <= '0;
            overflow   <= 1'b0;
        end else begin
            wr_pending <= input_read;
            hold_valid <= out_valid && !out_ready;
            hold_vc    <= grant;
            if (xfer)         rr_ptr   <= grant + 1'b1;
            if (overflow_set) overflow <= 1'b1;
        end
    end

endmodule
